// File: rtl/ahb_arbiter_pkg.sv
// rtl/ahb_arbiter_pkg.sv - AHB arbiter shared types, beat-count constants and burst helper
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        ARB_OPEN   = 2'b00,
        ARB_BURST  = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_t;

    // Beats remaining after the NONSEQ beat of a fixed-length burst
    localparam logic [3:0] BEATS4_CNT  = 4'd3;
    localparam logic [3:0] BEATS8_CNT  = 4'd7;
    localparam logic [3:0] BEATS16_CNT = 4'd15;

    // Zero means the burst has no fixed length and never holds the grant
    function automatic logic [3:0] burst_init_cnt(input hburst_t b);
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  return BEATS4_CNT;
            HBURST_WRAP8,  HBURST_INCR8:  return BEATS8_CNT;
            HBURST_WRAP16, HBURST_INCR16: return BEATS16_CNT;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// rtl/ahb_arbiter_rr_picker.sv - combinational round-robin picker, search starts after rr_ptr and wraps
module ahb_rr_picker #(
    parameter int N = 11,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] rr_ptr_i,
    output logic [N-1:0] grant_oh_o,
    output logic [W-1:0] grant_idx_o,
    output logic         valid_o
);

    logic [W:0]   sum;
    logic [W-1:0] idx;

    // The pointer itself is visited last, so a requesting owner only keeps the bus when nobody else asks
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, rr_ptr_i} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            idx = sum[W-1:0];
            if (!valid_o && req_i[idx]) begin
                valid_o          = 1'b1;
                grant_idx_o      = idx;
                grant_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB split-capable round-robin bus arbiter with burst, lock and split tracking
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 11,
    parameter int DEFAULT_MASTER = 0,
    parameter int MASTER_W       = 4
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] busreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MASTER_W-1:0]    hmaster,
    output logic                   hmastlock
);

    localparam logic [MASTER_W-1:0]    DEF_IDX = MASTER_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state_q,      state_d;
    logic [3:0]             burst_cnt_q,  burst_cnt_d;
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [MASTER_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [MASTER_W-1:0]    grant_idx_q,  grant_idx_d;
    logic [NUM_MASTERS-1:0] hgrant_q,     hgrant_d;
    logic [MASTER_W-1:0]    hmaster_q,    hmaster_d;
    logic                   hmastlock_q,  hmastlock_d;
    logic                   resp_busy_q,  resp_busy_d;

    htrans_t                trans;
    hburst_t                burst;
    hresp_t                 resp;
    logic                   resp_first;
    logic [NUM_MASTERS-1:0] split_set;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [MASTER_W-1:0]    pick_idx;
    logic                   pick_valid;
    logic                   arb_en;
    logic                   lock_req;
    logic [3:0]             init_cnt;

    assign trans    = htrans_t'(htrans);
    assign burst    = hburst_t'(hburst);
    assign resp     = hresp_t'(hresp);
    assign init_cnt = burst_init_cnt(burst);
    assign lock_req = hlock[grant_idx_q];

    // Only the first cycle of a two-cycle response acts; resp_busy_q marks the second
    always_comb begin
        resp_first  = !hready && (resp != HRESP_OKAY) && !resp_busy_q;
        resp_busy_d = !hready && (resp != HRESP_OKAY);
        split_set   = '0;
        if (resp_first && (resp == HRESP_SPLIT) && (hmaster_q != DEF_IDX)) begin
            split_set[hmaster_q] = 1'b1;
        end
        split_mask_d = (split_mask_q & ~hsplit) | split_set;
        eligible     = busreq & ~(split_mask_q | split_set);
    end

    ahb_rr_picker #(
        .N (NUM_MASTERS),
        .W (MASTER_W)
    ) u_picker (
        .req_i       (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        arb_en      = 1'b0;
        case (state_q)
            ARB_OPEN: begin
                if (lock_req) begin
                    state_d = ARB_LOCKED;
                end else if (hready && (trans == HTRANS_NONSEQ) && (init_cnt != 4'd0)) begin
                    state_d     = ARB_BURST;
                    burst_cnt_d = init_cnt;
                end else begin
                    arb_en = 1'b1;
                end
            end
            ARB_BURST: begin
                if (hready) begin
                    if (trans == HTRANS_SEQ) begin
                        if (burst_cnt_q <= 4'd1) begin
                            state_d     = ARB_OPEN;
                            burst_cnt_d = 4'd0;
                            arb_en      = 1'b1;
                        end else begin
                            burst_cnt_d = burst_cnt_q - 4'd1;
                        end
                    end else if (trans != HTRANS_BUSY) begin
                        state_d     = ARB_OPEN;
                        burst_cnt_d = 4'd0;
                        arb_en      = 1'b1;
                    end
                end
            end
            ARB_LOCKED: begin
                // Final address of the locked sequence still belongs to the locked master
                if (!lock_req && hready) begin
                    state_d = ARB_OPEN;
                end
            end
            default: begin
                state_d     = ARB_OPEN;
                burst_cnt_d = 4'd0;
            end
        endcase
        if (resp_first && ((resp == HRESP_RETRY) || (resp == HRESP_SPLIT))) begin
            state_d     = ARB_OPEN;
            burst_cnt_d = 4'd0;
            arb_en      = 1'b1;
        end
    end

    always_comb begin
        grant_idx_d = grant_idx_q;
        hgrant_d    = hgrant_q;
        rr_ptr_d    = rr_ptr_q;
        if (arb_en) begin
            grant_idx_d = pick_valid ? pick_idx : DEF_IDX;
            hgrant_d    = pick_valid ? pick_oh  : DEF_OH;
            if (grant_idx_d != grant_idx_q) begin
                rr_ptr_d = grant_idx_d;
            end
        end
        hmaster_d   = hready ? grant_idx_q        : hmaster_q;
        hmastlock_d = hready ? hlock[grant_idx_q] : hmastlock_q;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q      <= ARB_OPEN;
            burst_cnt_q  <= 4'd0;
            split_mask_q <= '0;
            rr_ptr_q     <= '0;
            grant_idx_q  <= DEF_IDX;
            hgrant_q     <= DEF_OH;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            resp_busy_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            split_mask_q <= split_mask_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            resp_busy_q  <= resp_busy_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;
    import ahb_arbiter_pkg::*;

    localparam int N = 11;

    logic         hclk = 1'b0;
    logic         hreset;
    logic [N-1:0] busreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [1:0]   hresp;
    logic [N-1:0] hsplit;
    logic [N-1:0] hgrant;
    logic [3:0]   hmaster;
    logic         hmastlock;

    int tests_run    = 0;
    int tests_failed = 0;

    ahb_arbiter dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .busreq    (busreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        busreq = '0;
        hlock  = '0;
        htrans = 2'b00;
        hburst = 3'b000;
        hready = 1'b1;
        hresp  = 2'b00;
        hsplit = '0;
        step();
        step();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (hgrant !== 11'h001) begin
                tests_failed++;
                $display("FAIL reset_hgrant cycle%0d got=%h exp=001", c, hgrant);
            end
            tests_run++;
            if (hmaster !== 4'd0) begin
                tests_failed++;
                $display("FAIL reset_hmaster cycle%0d got=%0d exp=0", c, hmaster);
            end
            tests_run++;
            if (hmastlock !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hmastlock cycle%0d got=%b exp=0", c, hmastlock);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        int exp_g [4] = '{3, 5, 3, 5};
        int exp_m [4] = '{0, 3, 5, 3};
        logic [N-1:0] eg;
        do_reset();
        busreq = 11'h028;
        htrans = 2'b10;
        hburst = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            eg = N'(1) << exp_g[i];
            tests_run++;
            if (hgrant !== eg) begin
                tests_failed++;
                $display("FAIL rr_grant step%0d got=%h exp=%h", i, hgrant, eg);
            end
            tests_run++;
            if (hmaster !== 4'(exp_m[i])) begin
                tests_failed++;
                $display("FAIL rr_hmaster step%0d got=%0d exp=%0d", i, hmaster, exp_m[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [1:0] tr [10] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
        logic       rd [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] eg;
        do_reset();
        busreq = 11'h004;
        step();
        step();
        htrans = 2'b10;
        hburst = 3'b101;
        busreq = 11'h084;
        step();
        tests_run++;
        if (hgrant !== 11'h004) begin
            tests_failed++;
            $display("FAIL burst_start_grant got=%h exp=004", hgrant);
        end
        for (int i = 0; i < 10; i++) begin
            htrans = tr[i];
            hready = rd[i];
            step();
            eg = (i == 9) ? 11'h080 : 11'h004;
            tests_run++;
            if (hgrant !== eg) begin
                tests_failed++;
                $display("FAIL burst_grant beat%0d got=%h exp=%h", i, hgrant, eg);
            end
            tests_run++;
            if (hmaster !== 4'd2) begin
                tests_failed++;
                $display("FAIL burst_hmaster beat%0d got=%0d exp=2", i, hmaster);
            end
        end
        htrans = 2'b00;
        hready = 1'b1;
        busreq = 11'h080;
        step();
        tests_run++;
        if (hmaster !== 4'd7) begin
            tests_failed++;
            $display("FAIL burst_handover_hmaster got=%0d exp=7", hmaster);
        end
    endtask

    task automatic test_locked();
        do_reset();
        busreq = 11'h010;
        hlock  = 11'h010;
        step();
        step();
        busreq = 11'h012;
        htrans = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (hgrant !== 11'h010 || hmaster !== 4'd4 || hmastlock !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold xfer%0d got g=%h m=%0d l=%b exp g=010 m=4 l=1", i, hgrant, hmaster, hmastlock);
            end
        end
        hlock  = 11'h000;
        busreq = 11'h002;
        step();
        tests_run++;
        if (hgrant !== 11'h010 || hmaster !== 4'd4) begin
            tests_failed++;
            $display("FAIL lock_final_xfer got g=%h m=%0d exp g=010 m=4", hgrant, hmaster);
        end
        htrans = 2'b00;
        step();
        tests_run++;
        if (hgrant !== 11'h002) begin
            tests_failed++;
            $display("FAIL lock_release_grant got=%h exp=002", hgrant);
        end
        step();
        tests_run++;
        if (hmaster !== 4'd1 || hmastlock !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_release_hmaster got m=%0d l=%b exp m=1 l=0", hmaster, hmastlock);
        end
    endtask

    task automatic test_split();
        do_reset();
        busreq = 11'h040;
        step();
        step();
        htrans = 2'b10;
        step();
        htrans = 2'b00;
        hready = 1'b0;
        hresp  = 2'b11;
        busreq = 11'h044;
        step();
        tests_run++;
        if (hgrant !== 11'h004 || hmaster !== 4'd6) begin
            tests_failed++;
            $display("FAIL split_first got g=%h m=%0d exp g=004 m=6", hgrant, hmaster);
        end
        hready = 1'b1;
        step();
        tests_run++;
        if (hgrant !== 11'h004 || hmaster !== 4'd2) begin
            tests_failed++;
            $display("FAIL split_second got g=%h m=%0d exp g=004 m=2", hgrant, hmaster);
        end
        hresp  = 2'b00;
        busreq = 11'h040;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (hgrant !== 11'h001) begin
                tests_failed++;
                $display("FAIL split_masked cycle%0d got=%h exp=001", i, hgrant);
            end
        end
        hsplit = 11'h040;
        step();
        tests_run++;
        if (hgrant !== 11'h001) begin
            tests_failed++;
            $display("FAIL split_clear_edge got=%h exp=001", hgrant);
        end
        hsplit = 11'h000;
        step();
        tests_run++;
        if (hgrant !== 11'h040) begin
            tests_failed++;
            $display("FAIL split_regrant got=%h exp=040", hgrant);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        busreq = 11'h008;
        step();
        step();
        htrans = 2'b10;
        hburst = 3'b110;
        step();
        htrans = 2'b11;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (hgrant !== 11'h008 || dut.state_q !== ARB_BURST || dut.burst_cnt_q !== 4'd11) begin
            tests_failed++;
            $display("FAIL wrap16_beat5 got g=%h st=%0d cnt=%0d exp g=008 st=1 cnt=11",
                     hgrant, dut.state_q, dut.burst_cnt_q);
        end
        hreset = 1'b1;
        step();
        tests_run++;
        if (hgrant !== 11'h001 || hmaster !== 4'd0 || hmastlock !== 1'b0) begin
            tests_failed++;
            $display("FAIL midburst_reset_outputs got g=%h m=%0d l=%b exp g=001 m=0 l=0", hgrant, hmaster, hmastlock);
        end
        tests_run++;
        if (dut.state_q !== ARB_OPEN || dut.burst_cnt_q !== 4'd0 || dut.split_mask_q !== 11'h000) begin
            tests_failed++;
            $display("FAIL midburst_reset_state got st=%0d cnt=%0d mask=%h exp st=0 cnt=0 mask=000",
                     dut.state_q, dut.burst_cnt_q, dut.split_mask_q);
        end
        hreset = 1'b0;
        htrans = 2'b00;
        step();
        tests_run++;
        if (hgrant !== 11'h008) begin
            tests_failed++;
            $display("FAIL post_reset_rearb got=%h exp=008", hgrant);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_locked();
        test_split();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
